mul_div_control: RTL and testbench
==================================

# mul_div_control

Control sequencer for the Phase 1 datapath's multiply/divide instructions. It replaces hand-driven bench stimulus with a Moore FSM. For each instruction it steps through fetch (T0–T2) and execute (T3–T6) and drives the datapath's strobe inputs, routing the 64-bit Z result into LO and HI. It sits beside the datapath. It waits on the memory read and on a possibly multi-cycle ALU through ready/done handshakes, with a watchdog on the ALU wait.

## Interface
- ALU_TIMEOUT, 64: maximum cycles waited in T4 for alu_done before aborting.
- Clock  in  1  system clock; all state changes on rising edge.
- Clear  in  1  reset, synchronous, active-high.
- Run  in  1  start request, sampled only in IDLE.
- IR_op  in  5  IR[31:27] from the datapath IR, valid from T3.
- mem_ready  in  1  memory read data valid; checked in T1.
- alu_done  in  1  ALU result valid on Z inputs; checked in T4.
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin  out  1 each  fetch strobes.
- Gra, Grb, Rout  out  1 each  register-file select: Ra field, Rb field, drive bus.
- Yin, ZLowIn, ZHighIn, Zlowout, Zhighout, LOin, HIin  out  1 each  execute strobes.
- op_code  out  5  ALU operation; 5'b00000 except in T4.
- alu_start  out  1  one-cycle pulse on entry to T4.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  high for one cycle in T6.
- Fault  out  1  one-cycle pulse on illegal opcode or ALU timeout.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, ABORT.
- All strobes are Moore-decoded from the state register; no output depends combinationally on an input.
- IDLE: all outputs 0. Run=1 moves to T0.
- T0: PCout, MARin, IncPC. Moves to T1.
- T1: Read, MDRin, PCin. Stays in T1 while mem_ready=0, then moves to T2.
  - Read and MDRin stay asserted for every cycle spent in T1.
  - PCin is asserted only in the first T1 cycle, so PC+1 loads exactly once.
- T2: MDRout, IRin. Moves to T3.
- T3: Gra, Rout, Yin.
  - IR_op is latched into op_reg on this cycle.
  - If op_reg ≠ MUL (5'b01100) and ≠ DIV (5'b01101), the next state is ABORT. Otherwise it is T4.
- T4: Grb, Rout, op_code=op_reg, ZLowIn, ZHighIn.
  - alu_start is asserted in the first T4 cycle only.
  - Stays in T4 until alu_done=1, then moves to T5.
  - A watchdog counter (clog2(ALU_TIMEOUT+1) bits) clears on entry to T4 and increments each T4 cycle. When it reaches ALU_TIMEOUT with alu_done still 0, the next state is ABORT.
- T5: Zlowout, LOin. Moves to T6.
- T6: Zhighout, HIin, Done. Moves to IDLE.
- ABORT: Fault=1, all other strobes 0 except Busy. Moves to IDLE.
- Run asserted outside IDLE is ignored; it is not queued.

## Timing
- Reset: Clear=1 at a rising edge forces IDLE, op_reg=0 and watchdog=0. All outputs are 0 in the following cycle, including mid-instruction; a pending T1 or T4 wait is dropped.
- Clear has priority over Run and over every handshake.
- Minimum latency, with mem_ready and alu_done already high: Run sampled at edge k gives T0 in cycle k+1 and T6/Done in cycle k+7. That is 7 Busy cycles, and Run is accepted again at edge k+8.
- Each extra cycle of mem_ready=0 or alu_done=0 adds exactly one cycle.
- alu_done=1 on the same edge the watchdog reaches ALU_TIMEOUT: done wins and the FSM goes to T5.
- Illegal opcode: 4 Busy cycles (T0–T3), then ABORT with Fault, then IDLE.
- Watchdog: abort when ALU_TIMEOUT consecutive T4 cycles pass with alu_done=0. The Fault/ABORT cycle follows that last T4 cycle.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - the state enum (4-bit binary encoding, IDLE=0);
  - opcode constants OP_MUL=5'b01100 and OP_DIV=5'b01101;
  - the ALU_TIMEOUT default.
- One sub-module, ctrl_watchdog: a loadable up-counter with clear, enable and expired outputs. The FSM, output decode and op_reg stay in mul_div_control.

## Test plan
- Reset mid-T4 (Clear at cycle 5 after Run): next cycle all outputs 0, state IDLE. A new Run then completes a normal 7-cycle sequence.
- MUL, no stalls: IR_op=5'b01100 with mem_ready=alu_done=1, operands 1637 and 5877 preloaded in datapath R6/R7. Required response:
  - Done in cycle 7 after Run;
  - op_code=5'b01100 only in T4;
  - LO = 9620649, HI = 0 in the datapath.
- DIV with stalls: mem_ready low 3 cycles, alu_done low 10 cycles, R6/R7 = 5877/1637. Required response:
  - Busy exactly 20 cycles;
  - alu_start a single pulse;
  - PCin a single pulse;
  - LO = 3, HI = 966.
- Illegal opcode: IR_op=5'b00011 gives Fault pulse in cycle 5 after Run, no ZLowIn/LOin/HIin ever asserted, then IDLE.
- ALU timeout: ALU_TIMEOUT=8 with alu_done held 0 gives exactly 8 T4 cycles, Fault pulse, IDLE, and no LOin. Repeat with alu_done rising on the 8th cycle: the FSM goes to T5 with no Fault.
- Run held high continuously: back-to-back instructions, Done every 8 cycles, Run ignored while Busy.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state, opcode and timeout definitions for the control sequencer
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_ABORT = 4'd8
  } state_e;

  localparam logic [4:0] OP_MUL = 5'b01100;
  localparam logic [4:0] OP_DIV = 5'b01101;

  localparam int ALU_TIMEOUT_DEFAULT = 64;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// rtl/ctrl_watchdog.sv - loadable saturating up-counter that flags the last permitted wait cycle
module ctrl_watchdog #(
  parameter int LIMIT = 64,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (enable_i && (count_q != W'(LIMIT))) begin
      count_d = count_q + W'(1);
    end
  end

  // High in the cycle whose increment brings the count to LIMIT.
  assign expired_o = enable_i && (count_q == W'(LIMIT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mul_div_control.sv
// rtl/mul_div_control.sv - Moore sequencer driving datapath strobes for MUL/DIV instructions
module mul_div_control
  import cpu_ctrl_pkg::*;
#(
  parameter int ALU_TIMEOUT = ALU_TIMEOUT_DEFAULT
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       Run,
  input  logic [4:0] IR_op,
  input  logic       mem_ready,
  input  logic       alu_done,
  output logic       PCout,
  output logic       MARin,
  output logic       IncPC,
  output logic       PCin,
  output logic       Read,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       Gra,
  output logic       Grb,
  output logic       Rout,
  output logic       Yin,
  output logic       ZLowIn,
  output logic       ZHighIn,
  output logic       Zlowout,
  output logic       Zhighout,
  output logic       LOin,
  output logic       HIin,
  output logic [4:0] op_code,
  output logic       alu_start,
  output logic       Busy,
  output logic       Done,
  output logic       Fault
);

  state_e     state_q, state_d;
  logic [4:0] op_reg_q, op_reg_d;
  logic       first_q, first_d;
  logic       wd_expired;

  ctrl_watchdog #(
    .LIMIT(ALU_TIMEOUT)
  ) u_watchdog (
    .clk_i     (Clock),
    .rst_i     (Clear),
    .clear_i   (state_q != S_T4),
    .enable_i  (state_q == S_T4),
    .load_i    (1'b0),
    .load_val_i('0),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Run) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    if (mem_ready) state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = is_muldiv(IR_op) ? S_T4 : S_ABORT;
      S_T4: begin
        if (alu_done)        state_d = S_T5;
        else if (wd_expired) state_d = S_ABORT;
      end
      S_T5:    state_d = S_T6;
      S_T6:    state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign op_reg_d = (state_q == S_T3) ? IR_op : op_reg_q;
  // Marks the first cycle of each state so PCin and alu_start fire once per visit.
  assign first_d  = (state_d != state_q);

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q  <= S_IDLE;
      op_reg_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_reg_q <= op_reg_d;
      first_q  <= first_d;
    end
  end

  always_comb begin
    {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin} = '0;
    {Gra, Grb, Rout, Yin, ZLowIn, ZHighIn, Zlowout, Zhighout, LOin, HIin} = '0;
    op_code   = '0;
    alu_start = 1'b0;
    Done      = 1'b0;
    Fault     = 1'b0;
    Busy      = (state_q != S_IDLE);
    case (state_q)
      S_T0: {PCout, MARin, IncPC} = 3'b111;
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        PCin  = first_q;
      end
      S_T2: {MDRout, IRin} = 2'b11;
      S_T3: {Gra, Rout, Yin} = 3'b111;
      S_T4: begin
        {Grb, Rout, ZLowIn, ZHighIn} = 4'b1111;
        op_code   = op_reg_q;
        alu_start = first_q;
      end
      S_T5:    {Zlowout, LOin} = 2'b11;
      S_T6:    {Zhighout, HIin, Done} = 3'b111;
      S_ABORT: Fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_div_control.sv
// tb/tb_mul_div_control.sv - scoreboard bench for mul_div_control with two watchdog limits
module tb_mul_div_control;

  localparam int TMO_A = 64;
  localparam int TMO_B = 8;

  typedef struct {
    logic [4:0]  op;
    int          busy;
    bit          done;
    bit          fault;
    int          pcin;
    int          astart;
    int          zin;
    int          loin;
    int          hiin;
    logic [31:0] lo;
    logic [31:0] hi;
    bit          chk_gap;
  } exp_t;

  logic Clock = 1'b0;
  logic Clear = 1'b1;
  logic Run   = 1'b0;
  logic [4:0] IR_op = '0;
  logic [1:0] mem_ready, alu_done;
  logic [1:0] PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic [1:0] Gra, Grb, Rout, Yin, ZLowIn, ZHighIn, Zlowout, Zhighout, LOin, HIin;
  logic [1:0] alu_start, Busy, Done, Fault;
  logic [4:0] op_code [2];

  int          m_cfg = 0;
  int          a_cfg = 0;
  logic [31:0] opa = 32'd1;
  logic [31:0] opb = 32'd1;
  logic [31:0] exp_lo [2] = '{32'd0, 32'd0};
  logic [31:0] exp_hi [2] = '{32'd0, 32'd0};
  exp_t        exp_q [2][$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 Clock = ~Clock;

  task automatic check(input string name, input int g, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d", name, g, act, exp);
    end
  endtask

  function automatic logic [26:0] outs(input int g);
    return {PCout[g], MARin[g], IncPC[g], PCin[g], Read[g], MDRin[g], MDRout[g], IRin[g],
            Gra[g], Grb[g], Rout[g], Yin[g], ZLowIn[g], ZHighIn[g], Zlowout[g], Zhighout[g],
            LOin[g], HIin[g], alu_start[g], Busy[g], Done[g], Fault[g], op_code[g]};
  endfunction

  // Reference: cycle counts and results from the instruction-level rules.
  function automatic exp_t predict(input logic [4:0] op, input int m, input int a, input int tmo,
                                   input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] lo0, input logic [31:0] hi0, input bit gap);
    exp_t e;
    logic [63:0] p;
    e.op = op; e.lo = lo0; e.hi = hi0; e.pcin = 1; e.chk_gap = gap;
    e.done = 0; e.fault = 0; e.astart = 0; e.zin = 0; e.loin = 0; e.hiin = 0;
    if (op != 5'b01100 && op != 5'b01101) begin
      e.busy = 5 + m;
      e.fault = 1;
    end else if (a >= tmo) begin
      e.busy = 5 + m + tmo;
      e.fault = 1; e.astart = 1; e.zin = tmo;
    end else begin
      e.busy = 7 + m + a;
      e.done = 1; e.astart = 1; e.zin = a + 1; e.loin = 1; e.hiin = 1;
      if (op == 5'b01100) begin
        p = 64'(x) * 64'(y);
        e.lo = p[31:0];
        e.hi = p[63:32];
      end else begin
        e.lo = x / y;
        e.hi = x % y;
      end
    end
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_ch
    int          rd_cnt = 0;
    int          alu_cnt = 0;
    logic [63:0] z = '0;
    logic [31:0] lo_r = '0;
    logic [31:0] hi_r = '0;
    int          idle_bad = 0;

    mul_div_control #(
      .ALU_TIMEOUT(g == 0 ? TMO_A : TMO_B)
    ) dut (
      .Clock(Clock), .Clear(Clear), .Run(Run), .IR_op(IR_op),
      .mem_ready(mem_ready[g]), .alu_done(alu_done[g]),
      .PCout(PCout[g]), .MARin(MARin[g]), .IncPC(IncPC[g]), .PCin(PCin[g]),
      .Read(Read[g]), .MDRin(MDRin[g]), .MDRout(MDRout[g]), .IRin(IRin[g]),
      .Gra(Gra[g]), .Grb(Grb[g]), .Rout(Rout[g]), .Yin(Yin[g]),
      .ZLowIn(ZLowIn[g]), .ZHighIn(ZHighIn[g]), .Zlowout(Zlowout[g]), .Zhighout(Zhighout[g]),
      .LOin(LOin[g]), .HIin(HIin[g]), .op_code(op_code[g]), .alu_start(alu_start[g]),
      .Busy(Busy[g]), .Done(Done[g]), .Fault(Fault[g])
    );

    // Memory and ALU responders plus the Z/LO/HI registers of the datapath.
    assign mem_ready[g] = (rd_cnt >= m_cfg);
    assign alu_done[g]  = (alu_cnt >= a_cfg);

    always @(posedge Clock) begin
      rd_cnt  <= Read[g] ? rd_cnt + 1 : 0;
      alu_cnt <= ZLowIn[g] ? alu_cnt + 1 : 0;
      if (ZLowIn[g] && ZHighIn[g]) begin
        case (op_code[g])
          5'b01100: z <= {32'd0, opa} * {32'd0, opb};
          5'b01101: z <= {opa % opb, opa / opb};
          default:  z <= 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
      end
      if (LOin[g]) lo_r <= z[31:0];
      if (HIin[g]) hi_r <= z[63:32];
    end

    initial begin
      exp_t cur;
      bit   in_ep = 0, have_cur = 0;
      int   busy_n = 0, pcin_n = 0, as_n = 0, zin_n = 0, lo_n = 0, hi_n = 0;
      int   done_n = 0, fault_n = 0, ev_at = 0, opbad = 0, gap = 0;
      int   last_done = -100, cyc = 0;
      forever begin
        @(negedge Clock);
        cyc++;
        if (Busy[g]) begin
          if (!in_ep) begin
            in_ep = 1;
            {busy_n, pcin_n, as_n, zin_n, lo_n, hi_n, done_n, fault_n, ev_at, opbad} = '0;
            gap = -1;
            if (exp_q[g].size() == 0) begin
              check("unexpected_start", g, 1, 0);
              have_cur = 0;
            end else begin
              cur = exp_q[g].pop_front();
              have_cur = 1;
            end
          end
          busy_n++;
          pcin_n += int'(PCin[g]);
          as_n   += int'(alu_start[g]);
          zin_n  += int'(ZLowIn[g]);
          lo_n   += int'(LOin[g]);
          hi_n   += int'(HIin[g]);
          if (Done[g]) begin
            done_n++; ev_at = busy_n; gap = cyc - last_done; last_done = cyc;
          end
          if (Fault[g]) begin
            fault_n++; ev_at = busy_n;
          end
          if (have_cur && (ZLowIn[g] ? (op_code[g] != cur.op) : (op_code[g] != 5'd0))) opbad++;
        end else begin
          if (in_ep) begin
            in_ep = 0;
            if (have_cur) begin
              check("busy_cycles", g, busy_n, cur.busy);
              check("done_pulses", g, done_n, int'(cur.done));
              check("fault_pulses", g, fault_n, int'(cur.fault));
              if (cur.done || cur.fault) check("event_cycle", g, ev_at, cur.busy);
              check("pcin_pulses", g, pcin_n, cur.pcin);
              check("alu_start_pulses", g, as_n, cur.astart);
              check("t4_cycles", g, zin_n, cur.zin);
              check("loin_cycles", g, lo_n, cur.loin);
              check("hiin_cycles", g, hi_n, cur.hiin);
              check("op_code_outside_t4", g, opbad, 0);
              check("lo_value", g, lo_r, cur.lo);
              check("hi_value", g, hi_r, cur.hi);
              if (cur.chk_gap) check("done_spacing", g, gap, 8);
            end
          end
          if (cyc > 3 && outs(g) != '0) idle_bad++;
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge Clock);
    while (Busy != 2'b00 && k < 400) begin
      @(negedge Clock);
      k++;
    end
    if (Busy != 2'b00) check("idle_wait_timeout", 0, 1, 0);
  endtask

  task automatic push_exp(input logic [4:0] op, input int m, input int a,
                          input logic [31:0] x, input logic [31:0] y, input bit gap);
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      e = predict(op, m, a, (g == 0) ? TMO_A : TMO_B, x, y, exp_lo[g], exp_hi[g], gap);
      exp_q[g].push_back(e);
      exp_lo[g] = e.lo;
      exp_hi[g] = e.hi;
    end
  endtask

  task automatic issue(input logic [4:0] op, input int m, input int a,
                       input logic [31:0] x, input logic [31:0] y);
    wait_idle();
    IR_op = op; m_cfg = m; a_cfg = a; opa = x; opb = y;
    push_exp(op, m, a, x, y, 1'b0);
    Run = 1'b1;
    @(negedge Clock);
    Run = 1'b0;
    for (int g = 0; g < 2; g++) check("busy_after_run", g, Busy[g], 1);
  endtask

  initial begin
    exp_t e;
    logic [4:0] op;
    repeat (3) @(negedge Clock);
    for (int g = 0; g < 2; g++) check("reset_outputs", g, outs(g), 0);
    Clear = 1'b0;

    // Clear while waiting in T4.
    wait_idle();
    IR_op = 5'b01100; m_cfg = 0; a_cfg = 20; opa = 32'd7; opb = 32'd9;
    for (int g = 0; g < 2; g++) begin
      e = predict(5'b01100, 0, 0, TMO_A, opa, opb, exp_lo[g], exp_hi[g], 1'b0);
      e.busy = 5; e.done = 0; e.zin = 1; e.loin = 0; e.hiin = 0;
      e.lo = exp_lo[g]; e.hi = exp_hi[g];
      exp_q[g].push_back(e);
    end
    Run = 1'b1;
    @(negedge Clock);
    Run = 1'b0;
    repeat (4) @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    for (int g = 0; g < 2; g++) check("clear_mid_t4_outputs", g, outs(g), 0);
    Clear = 1'b0;

    issue(5'b01100, 0, 0, 32'd1637, 32'd5877);
    wait_idle();
    check("mul_lo_const", 0, g_ch[0].lo_r, 9620649);
    check("mul_hi_const", 0, g_ch[0].hi_r, 0);

    issue(5'b01101, 3, 10, 32'd5877, 32'd1637);
    wait_idle();
    check("div_lo_const", 0, g_ch[0].lo_r, 3);
    check("div_hi_const", 0, g_ch[0].hi_r, 966);

    issue(5'b00011, 0, 0, 32'd5, 32'd6);
    issue(5'b01100, 0, 8, 32'd11, 32'd13);
    issue(5'b01101, 0, 7, 32'd1000, 32'd7);
    issue(5'b01100, 2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Run held high: three back-to-back instructions.
    wait_idle();
    IR_op = 5'b01100; m_cfg = 0; a_cfg = 0; opa = 32'd321; opb = 32'd654;
    for (int i = 0; i < 3; i++) push_exp(5'b01100, 0, 0, opa, opb, i != 0);
    Run = 1'b1;
    repeat (17) @(negedge Clock);
    Run = 1'b0;

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    op = 5'b01100;
        2:       op = 5'b01101;
        default: begin
          op = 5'($urandom);
          if (op == 5'b01100 || op == 5'b01101) op = 5'b11111;
        end
      endcase
      issue(op, int'($urandom_range(0, 4)), int'($urandom_range(0, 12)),
            $urandom, 32'($urandom_range(1, 65535)));
    end

    wait_idle();
    repeat (3) @(negedge Clock);
    for (int g = 0; g < 2; g++) check("queue_drained", g, exp_q[g].size(), 0);
    check("idle_outputs_zero", 0, g_ch[0].idle_bad, 0);
    check("idle_outputs_zero", 1, g_ch[1].idle_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
